// File: rtl/or7_equiv_sweeper_pkg.sv
// Shared definitions for the OR7 equivalence sweeper: default sizes,
// vector count and the sequencing state encoding.
package or7_equiv_sweeper_pkg;

    localparam int NUM_IN_DEF  = 7;
    localparam int NUM_OUT_DEF = 2;
    localparam int NUM_VEC     = 2 ** NUM_IN_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/or7_equiv_sweeper_if.sv
// Bundle of control, stimulus and result signals between the sweeper and
// its environment (the two circuits under test plus whoever starts sweeps).
interface or7_equiv_sweeper_if
    import or7_equiv_sweeper_pkg::*;
#(
    parameter int NUM_IN  = NUM_IN_DEF,
    parameter int NUM_OUT = NUM_OUT_DEF
);

    logic                START;
    logic                ABORT;
    logic [NUM_IN-1:0]   I;
    logic [NUM_OUT-1:0]  OA;
    logic [NUM_OUT-1:0]  OB;
    logic [NUM_OUT-1:0]  MASK;
    logic                BUSY;
    logic                DONE;
    logic                EQUIV;
    logic [NUM_IN:0]     ERR_CNT;
    logic [NUM_IN-1:0]   FIRST_BAD;

    // Environment side: launches sweeps and returns the circuit outputs.
    modport master (
        output START, ABORT, OA, OB, MASK,
        input  I, BUSY, DONE, EQUIV, ERR_CNT, FIRST_BAD
    );

    // Sweeper side: produces stimulus and reports the comparison results.
    modport slave (
        input  START, ABORT, OA, OB, MASK,
        output I, BUSY, DONE, EQUIV, ERR_CNT, FIRST_BAD
    );

endinterface

// File: rtl/or7_equiv_sweeper_miter_cmp.sv
// Miter comparator: flags a mismatch when any enabled output pair differs.
module or7_miter_cmp #(
    parameter int NUM_OUT = 2
) (
    input  logic [NUM_OUT-1:0] oa_i,
    input  logic [NUM_OUT-1:0] ob_i,
    input  logic [NUM_OUT-1:0] mask_i,
    output logic               mismatch_o
);

    // Masked XOR of the two circuits, reduced to a single mismatch flag.
    always_comb begin
        mismatch_o = |((oa_i ^ ob_i) & mask_i);
    end

endmodule

// File: rtl/or7_equiv_sweeper.sv
// Exhaustive equivalence sweeper: walks every input vector through two
// circuits, counts mismatching vectors and remembers the first one.
module or7_equiv_sweeper
    import or7_equiv_sweeper_pkg::*;
#(
    parameter int NUM_IN  = NUM_IN_DEF,
    parameter int NUM_OUT = NUM_OUT_DEF
) (
    input logic                 CLK,
    input logic                 RST,
    or7_equiv_sweeper_if.slave  bus
);

    localparam int                LOCAL_VEC = 2 ** NUM_IN;
    localparam logic [NUM_IN-1:0] LAST_VEC  = NUM_IN'(LOCAL_VEC - 1);
    localparam logic [NUM_IN-1:0] I_ONE     = NUM_IN'(1);
    localparam logic [NUM_IN:0]   ERR_ONE   = (NUM_IN + 1)'(1);

    sweep_state_t         state_q;
    logic [NUM_IN-1:0]    i_q;
    logic [NUM_OUT-1:0]   mask_q;
    logic [NUM_IN:0]      errCnt_q;
    logic [NUM_IN:0]      errCnt_d;
    logic [NUM_IN-1:0]    firstBad_q;
    logic [NUM_IN-1:0]    firstBad_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 equiv_q;
    logic                 mismatch;

    or7_miter_cmp #(
        .NUM_OUT (NUM_OUT)
    ) u_miter_cmp (
        .oa_i       (bus.OA),
        .ob_i       (bus.OB),
        .mask_i     (mask_q),
        .mismatch_o (mismatch)
    );

    // Result update for the vector currently on I: bump the count and, if it
    // is the first failure of this sweep, remember which vector it was.
    always_comb begin
        errCnt_d   = errCnt_q;
        firstBad_d = firstBad_q;
        if (mismatch) begin
            errCnt_d = errCnt_q + ERR_ONE;
            if (errCnt_q == '0) begin
                firstBad_d = i_q;
            end
        end
    end

    // Sweep sequencer; ABORT overrides everything, including a same-cycle START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            i_q        <= '0;
            mask_q     <= '0;
            errCnt_q   <= '0;
            firstBad_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            equiv_q    <= 1'b0;
        end else if (bus.ABORT) begin
            state_q    <= IDLE;
            i_q        <= '0;
            errCnt_q   <= '0;
            firstBad_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            equiv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE_ST: begin
                    if (bus.START) begin
                        state_q    <= RUN;
                        i_q        <= '0;
                        mask_q     <= bus.MASK;
                        errCnt_q   <= '0;
                        firstBad_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        equiv_q    <= 1'b0;
                    end
                end
                RUN: begin
                    errCnt_q   <= errCnt_d;
                    firstBad_q <= firstBad_d;
                    if (i_q == LAST_VEC) begin
                        state_q <= DONE_ST;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        equiv_q <= (errCnt_d == '0);
                    end else begin
                        i_q <= i_q + I_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    equiv_q <= 1'b0;
                end
            endcase
        end
    end

    // All results leave straight from flops so OA/OB never reach an output.
    always_comb begin
        bus.I         = i_q;
        bus.BUSY      = busy_q;
        bus.DONE      = done_q;
        bus.EQUIV     = equiv_q;
        bus.ERR_CNT   = errCnt_q;
        bus.FIRST_BAD = firstBad_q;
    end

endmodule

// File: tb/tb_or7_equiv_sweeper.sv
// Bench for the OR7 equivalence sweeper: circuit A is an OR7 / NOR3 netlist,
// circuit B a De Morgan rewrite of it with selectable injected faults.
module tb_or7_equiv_sweeper;
    import or7_equiv_sweeper_pkg::*;

    typedef enum int {
        F_NONE,
        F_O1_SA0,
        F_O0_INV,
        F_O0_SA0,
        F_O1_SA1,
        F_O0_NO_I6
    } fault_t;

    typedef struct {
        fault_t     f;
        logic [1:0] mask;
        int         expErr;
        int         expFirst;
        logic       expEquiv;
    } vec_t;

    logic   CLK = 1'b0;
    logic   RST;
    fault_t fault;
    int     vecCount  = 0;
    int     failCount = 0;
    vec_t   vecs[10];

    or7_equiv_sweeper_if bus ();

    or7_equiv_sweeper dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Circuit A, and circuit B with the currently selected fault applied.
    always_comb begin
        bus.OA[0] = |bus.I;
        bus.OA[1] = ~((|bus.I[2:0]) | (|bus.I[4:3]) | (|bus.I[6:5]));
        bus.OB[0] = ~(&(~bus.I));
        bus.OB[1] = &(~bus.I);
        case (fault)
            F_O1_SA0:   bus.OB[1] = 1'b0;
            F_O0_INV:   bus.OB[0] = &(~bus.I);
            F_O0_SA0:   bus.OB[0] = 1'b0;
            F_O1_SA1:   bus.OB[1] = 1'b1;
            F_O0_NO_I6: bus.OB[0] = |bus.I[5:0];
            default:    ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " I"},         32'(bus.I),         0);
        checkOutput({tag, " BUSY"},      32'(bus.BUSY),      0);
        checkOutput({tag, " DONE"},      32'(bus.DONE),      0);
        checkOutput({tag, " EQUIV"},     32'(bus.EQUIV),     0);
        checkOutput({tag, " ERR_CNT"},   32'(bus.ERR_CNT),   0);
        checkOutput({tag, " FIRST_BAD"}, 32'(bus.FIRST_BAD), 0);
    endtask

    task automatic pulseStart();
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic waitForI(input int target);
        int n = 0;
        while (bus.I !== 7'(target) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        checkOutput($sformatf("reach I=%0d", target), 32'(bus.I), 32'(target));
    endtask

    // One full sweep: START, then count cycles from BUSY rising to DONE rising.
    task automatic applyStimulus(input fault_t f, input logic [1:0] mask,
                                 input int repulseAt, input int expErr,
                                 input int expFirst, input logic expEquiv,
                                 input string tag);
        int cyc = 0;
        fault    = f;
        bus.MASK = mask;
        pulseStart();
        bus.MASK = ~mask;
        checkOutput({tag, " BUSY rise"}, 32'(bus.BUSY), 1);
        checkOutput({tag, " I start"},   32'(bus.I),    0);
        while (bus.DONE !== 1'b1 && cyc < 300) begin
            bus.START = (repulseAt >= 0 && bus.I == 7'(repulseAt));
            @(negedge CLK);
            cyc++;
            if (cyc == 64) begin
                checkOutput({tag, " EQUIV mid-run"}, 32'(bus.EQUIV), 0);
            end
        end
        bus.START = 1'b0;
        checkOutput({tag, " DONE latency"}, 32'(cyc),         32'(NUM_VEC));
        checkOutput({tag, " BUSY fall"},    32'(bus.BUSY),    0);
        checkOutput({tag, " ERR_CNT"},      32'(bus.ERR_CNT), 32'(expErr));
        if (expErr != 0) begin
            checkOutput({tag, " FIRST_BAD"}, 32'(bus.FIRST_BAD), 32'(expFirst));
        end
        checkOutput({tag, " EQUIV"}, 32'(bus.EQUIV), 32'(expEquiv));
    endtask

    initial begin
        vecs[0] = '{F_NONE,     2'b11, 0,       0,  1'b1};
        vecs[1] = '{F_O1_SA0,   2'b11, 1,       0,  1'b0};
        vecs[2] = '{F_O0_INV,   2'b10, 0,       0,  1'b1};
        vecs[3] = '{F_O0_INV,   2'b01, NUM_VEC, 0,  1'b0};
        vecs[4] = '{F_NONE,     2'b00, 0,       0,  1'b1};
        vecs[5] = '{F_O0_INV,   2'b00, 0,       0,  1'b1};
        vecs[6] = '{F_O1_SA0,   2'b01, 0,       0,  1'b1};
        vecs[7] = '{F_O0_SA0,   2'b11, 127,     1,  1'b0};
        vecs[8] = '{F_O1_SA1,   2'b10, 127,     1,  1'b0};
        vecs[9] = '{F_O0_NO_I6, 2'b11, 1,       64, 1'b0};

        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.MASK  = 2'b00;
        fault     = F_NONE;
        RST       = 1'b1;
        repeat (2) @(negedge CLK);
        checkIdle("reset");
        RST = 1'b0;

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].f, vecs[v].mask, -1, vecs[v].expErr,
                          vecs[v].expFirst, vecs[v].expEquiv,
                          $sformatf("vec%0d", v));
        end

        // ABORT and START together while DONE is showing: ABORT must win.
        @(negedge CLK);
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        checkIdle("abort+start");

        // ABORT mid-sweep at I=40 with every vector failing.
        fault    = F_O0_INV;
        bus.MASK = 2'b11;
        pulseStart();
        waitForI(40);
        checkOutput("pre-abort ERR_CNT", 32'(bus.ERR_CNT), 40);
        bus.ABORT = 1'b1;
        @(negedge CLK);
        bus.ABORT = 1'b0;
        checkIdle("abort");
        applyStimulus(F_O0_INV, 2'b11, -1, NUM_VEC, 0, 1'b0, "post-abort");

        // Asynchronous reset mid-sweep at I=100.
        fault    = F_O0_INV;
        bus.MASK = 2'b01;
        pulseStart();
        waitForI(100);
        RST = 1'b1;
        #1;
        checkIdle("async reset");
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(F_NONE, 2'b11, -1, 0, 0, 1'b1, "post-reset");

        // START re-pulsed at I=10 must not disturb the running sweep.
        applyStimulus(F_NONE, 2'b11, 10, 0, 0, 1'b1, "restart-ignored");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
